// File: rtl/sipo_deframer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deframer
// Description : Serial-in/parallel-out deserializer. Collects WIDTH qualified
//               bits into a word, presents it with a valid/ack handshake and
//               raises a sticky overrun flag if an unacknowledged word is
//               overwritten by a newer one.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deframer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst,        // asynchronous, active-low
    input  logic                       din,
    input  logic                       din_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ack,
    output logic                       overrun,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_sr_next;
    logic             w_last;

    // Shift direction decides whether the first bit ends up in the MSB or LSB.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_sr_next = {r_sr[WIDTH-2:0], din};
        end else begin : g_lsb_first
            assign w_sr_next = {din, r_sr[WIDTH-1:1]};
        end
    endgenerate

    // A qualified bit that arrives while WIDTH-1 bits are already held completes a word.
    assign w_last = din_en && (r_cnt == c_LAST_CNT);

    // Shift register and bit counter; both hold while din_en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (din_en) begin
            r_sr <= w_sr_next;
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Output word, handshake and sticky overrun. The word loaded on completion
    // is the next shift-register value, so it includes the bit sampled now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_last) begin
                r_dout  <= w_sr_next;
                r_valid <= 1'b1;
                if (r_valid && !dout_ack) begin
                    r_overrun <= 1'b1;
                end
            end else if (dout_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign overrun    = r_overrun;
    assign bit_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deframer
// Description : Scoreboard bench driving one MSB-first and one LSB-first
//               deframer with the same serial stream. A word-level model
//               pushes the expected outputs after each edge; a monitor pops
//               and compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deframer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_en = 1'b0;
    logic       dout_ack = 1'b0;

    logic [7:0] dout_m, dout_l;
    logic       valid_m, valid_l, ovr_m, ovr_l;
    logic [2:0] cnt_m, cnt_l;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] wm;
        logic [7:0] wl;
        logic       v;
        logic       o;
        logic [2:0] c;
    } rec_t;

    rec_t q[$];

    // model state
    bit         bits[$];
    logic [7:0] m_wm = 8'h00;
    logic [7:0] m_wl = 8'h00;
    logic       m_v  = 1'b0;
    logic       m_o  = 1'b0;

    always #5 clk = ~clk;

    sipo_deframer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en),
        .dout(dout_m), .dout_valid(valid_m), .dout_ack(dout_ack),
        .overrun(ovr_m), .bit_cnt(cnt_m)
    );

    sipo_deframer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en),
        .dout(dout_l), .dout_valid(valid_l), .dout_ack(dout_ack),
        .overrun(ovr_l), .bit_cnt(cnt_l)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t cur_rec();
        rec_t r;
        r.wm = m_wm;
        r.wl = m_wl;
        r.v  = m_v;
        r.o  = m_o;
        r.c  = 3'(bits.size());
        return r;
    endfunction

    // Word-level reference: bits accumulate in arrival order; a full set of
    // eight is weighted by position to form the MSB-first and LSB-first words.
    task automatic model_edge(input bit d, input bit en, input bit ack);
        if (en) begin
            bits.push_back(d);
            if (bits.size() == 8) begin
                m_wm = 8'h00;
                m_wl = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    if (bits[i]) begin
                        m_wm = m_wm + (8'h80 >> i);
                        m_wl = m_wl + (8'h01 << i);
                    end
                end
                bits.delete();
                if (m_v && !ack) m_o = 1'b1;
                m_v = 1'b1;
                return;
            end
        end
        if (ack) m_v = 1'b0;
    endtask

    // Called just after a falling edge; returns on the next falling edge.
    task automatic cycle(input bit d, input bit en, input bit ack);
        #2;
        din = d;
        din_en = en;
        dout_ack = ack;
        @(posedge clk);
        #1;
        model_edge(d, en, ack);
        q.push_back(cur_rec());
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w, input bit ack_last);
        for (int i = 7; i >= 0; i--) begin
            cycle(w[i], 1'b1, (i == 0) ? ack_last : 1'b0);
        end
    endtask

    // Asserts reset between edges, checks outputs clear without a clock edge,
    // holds across one edge, then releases before the next edge.
    task automatic do_reset();
        #3;
        rst = 1'b0;
        din_en = 1'b0;
        dout_ack = 1'b0;
        #1;
        chk("rst_dout_m", dout_m, 8'h00);
        chk("rst_dout_l", dout_l, 8'h00);
        chk("rst_valid", {6'd0, valid_m, valid_l}, 8'h00);
        chk("rst_ovr", {6'd0, ovr_m, ovr_l}, 8'h00);
        chk("rst_cnt", {2'd0, cnt_m | cnt_l}, 8'h00);
        bits.delete();
        m_wm = 8'h00;
        m_wl = 8'h00;
        m_v  = 1'b0;
        m_o  = 1'b0;
        @(posedge clk);
        #1;
        q.push_back(cur_rec());
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: every falling edge with a pending expectation is compared.
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_dout_msb", dout_m, e.wm);
                chk("sb_dout_lsb", dout_l, e.wl);
                chk("sb_valid", {6'd0, valid_m, valid_l}, {6'd0, e.v, e.v});
                chk("sb_overrun", {6'd0, ovr_m, ovr_l}, {6'd0, e.o, e.o});
                chk("sb_bit_cnt_m", {5'd0, cnt_m}, {5'd0, e.c});
                chk("sb_bit_cnt_l", {5'd0, cnt_l}, {5'd0, e.c});
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();

        // 1/2: B2 pattern, seen as B2 MSB-first and 4D LSB-first
        send_word(8'hB2, 1'b0);
        #1;
        chk("s1_dout_msb", dout_m, 8'hB2);
        chk("s2_dout_lsb", dout_l, 8'h4D);
        chk("s1_valid", {7'd0, valid_m}, 8'h01);
        cycle(1'b0, 1'b0, 1'b1);
        #1;
        chk("s1_ack_clears", {7'd0, valid_m}, 8'h00);
        cycle(1'b1, 1'b0, 1'b1);

        // 3: gaps after bits 2 and 5, din random during gaps
        begin
            logic [7:0] w;
            w = 8'hB2;
            for (int i = 7; i >= 0; i--) begin
                cycle(w[i], 1'b1, 1'b0);
                if (i == 6 || i == 3) begin
                    for (int g = 0; g < 3; g++) cycle(1'($urandom), 1'b0, 1'b0);
                end
            end
        end
        #1;
        chk("s3_gap_dout", dout_m, 8'hB2);

        // 4: overrun with gapped word still pending
        send_word(8'h0F, 1'b0);
        #1;
        chk("s4_dout", dout_m, 8'h0F);
        chk("s4_overrun", {7'd0, ovr_m}, 8'h01);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        #1;
        chk("s4_sticky", {7'd0, ovr_m}, 8'h01);

        // 5: ack coincides with completion of the next word
        do_reset();
        send_word(8'hB2, 1'b0);
        send_word(8'hA5, 1'b1);
        #1;
        chk("s5_dout", dout_m, 8'hA5);
        chk("s5_valid", {7'd0, valid_m}, 8'h01);
        chk("s5_no_ovr", {7'd0, ovr_m}, 8'h00);
        cycle(1'b0, 1'b0, 1'b1);
        #1;
        chk("s5_ack_clears", {7'd0, valid_m}, 8'h00);

        // 6: reset mid-word discards partial bits
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0);
        do_reset();
        send_word(8'h01, 1'b0);
        #1;
        chk("s6_dout_msb", dout_m, 8'h01);
        chk("s6_dout_lsb", dout_l, 8'h80);

        // random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
        end

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Serial-in/parallel-out deserializer that sits directly downstream of the single-bit D flip-flop stage and consumes its registered serial bit stream.
- Collects WIDTH qualified bits into a word and presents the word with a valid/ack handshake.
- Flags an overrun when the consumer has not acknowledged a word before the next one completes.

Parameters:
- WIDTH, 8, bits per word (WIDTH >= 2).
- MSB_FIRST, 1, 1: first received bit lands in dout[WIDTH-1]; 0: first received bit lands in dout[0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit (the flip-flop q output).
- din_en  input  1  qualifies din; the bit is sampled only when high.
- dout  output  WIDTH  last completed word.
- dout_valid  output  1  dout holds an unacknowledged word.
- dout_ack  input  1  consumer accepts dout; only meaningful while dout_valid=1.
- overrun  output  1  sticky flag: a word was overwritten before being acked.
- bit_cnt  output  $clog2(WIDTH)  number of bits collected in the current partial word.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - Internal shift register = 0, bit_cnt = 0, dout = 0, dout_valid = 0, overrun = 0.
  - Reset acts immediately on assertion. Release is synchronous to the next clk edge.
- Shifting (each rising edge with din_en=1):
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], din}.
  - MSB_FIRST=0: sr <= {din, sr[WIDTH-1:1]}.
  - bit_cnt increments.
- din_en=0: sr and bit_cnt hold. Gaps of any length are allowed between bits.
- Word completion: an edge where din_en=1 and bit_cnt==WIDTH-1.
  - At that same edge, dout is loaded with the full word including the current bit.
  - At that same edge, dout_valid is set to 1 and bit_cnt wraps to 0.
  - Latency: dout/dout_valid are visible immediately after the edge that samples the WIDTH-th bit.
  - sr is not cleared; the next word overwrites it.
- Handshake:
  - dout_valid stays high, and dout stays stable, until a rising edge samples dout_ack=1 with dout_valid=1; dout_valid then clears at that edge.
  - dout_ack while dout_valid=0 is ignored.
  - dout holds its last value after ack.
- Simultaneous ack and word completion at the same edge:
  - New word loads into dout and dout_valid remains 1.
  - No overrun.
- Overrun: word completion while dout_valid=1 and dout_ack=0.
  - dout is overwritten with the newest word and dout_valid remains 1.
  - overrun is set to 1.
  - overrun is sticky; only reset clears it.
- Reset mid-word: the partial word is discarded and bit_cnt returns to 0. The first bit after release starts a new word.
- Reset while dout_valid=1: the word is lost and dout returns to 0.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Reset then shift, WIDTH=8, MSB_FIRST=1:
   - Stimulus: pulse rst low for 1 cycle; drive din sequence 1,0,1,1,0,0,1,0 with din_en=1 on consecutive edges.
   - Required: after the 8th edge, dout=8'hB2 and dout_valid=1. bit_cnt counts 1..7, then 0.
2. Same sequence with MSB_FIRST=0:
   - Required: dout=8'h4D, dout_valid=1.
3. Gapped input:
   - Stimulus: same bits as scenario 1, with din_en=0 for 3 cycles after bits 2 and 5; din toggles randomly during the gaps.
   - Required: dout=8'hB2. bit_cnt holds during the gaps.
4. Overrun:
   - Stimulus: complete 8'hB2 and hold dout_ack=0; complete a second word 8'h0F.
   - Required: dout=8'h0F, dout_valid=1, overrun=1. overrun stays 1 after a later ack.
5. Simultaneous ack:
   - Stimulus: complete 8'hB2; during the second word's 8th edge, drive dout_ack=1 while completing 8'hA5.
   - Required: dout=8'hA5, dout_valid=1, overrun=0. Next edge with ack=1: dout_valid=0.
6. Reset mid-word:
   - Stimulus: shift 4 bits (1,1,1,1); assert rst asynchronously between edges; release; shift 0,0,0,0,0,0,0,1.
   - Required: all outputs go to 0 immediately on assertion; the next word is dout=8'h01 with no stale bits.
